// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: a three-state IDLE/REQ/HOLD FSM.
// It issues memory requests, captures instruction words for decode and handles branch redirects.
module fetch_ctrl #(
   parameter logic [31:0] RESET_VEC = 32'h00000000,
   parameter logic [31:0] TRAP_VEC  = 32'h00000100
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        dec_ready,
   input  logic        redir_valid,
   input  logic [31:0] redir_target,
   output logic        misalign,
   output logic [31:0] pc,
   output logic [31:0] fetch_cnt
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

   state_t state;
   logic   handshake;
   logic   redir_bad;

   assign imem_addr = pc;
   assign handshake = (state == HOLD) && dec_ready;
   assign redir_bad = (redir_target[1:0] != 2'b00);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         pc         <= RESET_VEC;
         inst       <= '0;
         inst_pc    <= '0;
         fetch_cnt  <= '0;
         misalign   <= 1'b0;
         inst_valid <= 1'b0;
         imem_req   <= 1'b0;
      end else begin
         misalign <= 1'b0;
         // A handshake still counts even when a redirect lands in the same cycle
         if (handshake)
            fetch_cnt <= fetch_cnt + 32'd1;

         if (redir_valid) begin
            pc         <= redir_bad ? TRAP_VEC : redir_target;
            misalign   <= redir_bad;
            state      <= REQ;
            imem_req   <= 1'b1;
            inst_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state    <= REQ;
                  imem_req <= 1'b1;
               end
               REQ: begin
                  if (imem_gnt) begin
                     inst       <= imem_rdata;
                     inst_pc    <= pc;
                     pc         <= pc + 32'd4;
                     state      <= HOLD;
                     imem_req   <= 1'b0;
                     inst_valid <= 1'b1;
                  end
               end
               HOLD: begin
                  if (dec_ready) begin
                     state      <= REQ;
                     imem_req   <= 1'b1;
                     inst_valid <= 1'b0;
                  end
               end
               default: begin
                  state      <= IDLE;
                  imem_req   <= 1'b0;
                  inst_valid <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_VEC, default 32'h00000000, is the first fetch address after reset.
REQ-002 Parameter TRAP_VEC, default 32'h00000100, is the fetch address after a misaligned redirect.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction memory request, held high until granted.
REQ-006 imem_addr  output  32  fetch address; equals pc whenever imem_req is high.
REQ-007 imem_gnt  input  1  memory returns imem_rdata this cycle for imem_addr.
REQ-008 imem_rdata  input  32  instruction word, valid when imem_gnt is high.
REQ-009 inst_valid  output  1  inst and inst_pc are valid for decode.
REQ-010 inst  output  32  captured instruction word.
REQ-011 inst_pc  output  32  address inst was fetched from.
REQ-012 dec_ready  input  1  decode accepts inst this cycle; a handshake is inst_valid && dec_ready.
REQ-013 redir_valid  input  1  branch/jump redirect request, a one-cycle pulse.
REQ-014 redir_target  input  32  redirect target address.
REQ-015 misalign  output  1  one-cycle pulse flagging a redirect target with bits[1:0] != 0.
REQ-016 pc  output  32  current fetch program counter.
REQ-017 fetch_cnt  output  32  count of completed decode handshakes.

Function
REQ-018 The FSM SHALL have three states: IDLE, REQ and HOLD.
REQ-019 IDLE: all handshake outputs low; unconditional move to REQ on the next edge.
REQ-020 REQ: imem_req=1 and imem_addr=pc; stay in REQ while imem_gnt=0.
- On imem_gnt=1: inst<=imem_rdata, inst_pc<=pc, pc<=pc+4, move to HOLD.
REQ-021 HOLD: inst_valid=1 and imem_req=0; inst and inst_pc held stable.
- On dec_ready=1: move to REQ and increment fetch_cnt.
REQ-022 Fetch latency SHALL be one cycle: inst_valid rises on the edge after the imem_gnt cycle; the next imem_req rises on the edge after the handshake.
REQ-023 pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000); fetch_cnt SHALL wrap likewise.
REQ-024 Aligned redirect (redir_valid=1, redir_target[1:0]=0) in any state: pc<=redir_target, state<=REQ, inst_valid drops on the next edge.
REQ-025 Misaligned redirect: pc<=TRAP_VEC, state<=REQ, misalign=1 for the following cycle only.
REQ-026 Redirect SHALL take priority over imem_gnt: in REQ with both high, imem_rdata is discarded and inst/inst_pc are unchanged.
REQ-027 Redirect and handshake in the same HOLD cycle: the handshake completes (fetch_cnt increments) and the redirect applies.
REQ-028 Redirect in IDLE SHALL apply, and the state moves to REQ.
REQ-029 imem_gnt while not in REQ SHALL be ignored.
REQ-030 dec_ready while inst_valid=0 SHALL be ignored.
REQ-031 Outputs SHALL be registered, except imem_addr, which is driven directly from pc.

Reset
REQ-032 rst=0 SHALL asynchronously force: state=IDLE, pc=RESET_VEC, inst=0, inst_pc=0, fetch_cnt=0, misalign=0, inst_valid=0, imem_req=0.
REQ-033 Reset asserted mid-fetch or mid-HOLD SHALL abandon the transaction; the first imem_req after release is at RESET_VEC.
REQ-034 After rst deasserts, the block SHALL spend one cycle in IDLE, then raise imem_req.

Verification
REQ-035 Release reset; imem_gnt on the 3rd REQ cycle with rdata=32'h00500093; dec_ready=1 -> imem_addr=0 for 3 cycles, then inst_valid=1, inst=32'h00500093, inst_pc=0, then pc=4 and fetch_cnt=1.
REQ-036 Hold dec_ready=0 for 5 cycles in HOLD -> inst_valid stays 1, inst stable, imem_req stays 0, fetch_cnt unchanged.
REQ-037 Redirect to 32'h00000040 in the same REQ cycle as imem_gnt -> rdata discarded, next imem_addr=32'h40, no inst_valid for the old word.
REQ-038 Redirect to 32'h00000042 -> misalign pulses for 1 cycle, next imem_addr=TRAP_VEC (32'h100).
REQ-039 Redirect to 32'hFFFFFFFC, grant and handshake -> next imem_addr=32'h00000000.
REQ-040 Assert rst during HOLD with inst_valid=1 -> all outputs cleared immediately without a clock edge; first post-reset imem_addr=RESET_VEC.
